mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width.
REQ-002 Parameter N, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter DEPTH, default 4, maximum outstanding multiplier operations (tag FIFO depth); power of 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 i_x  input  N*WIDTH  operand per requester; slice k = requester k.
REQ-007 i_valid_in  input  N  per-requester operand valid.
REQ-008 i_ready_out  output  N  per-requester accept; at most one bit high.
REQ-009 m_x  output  WIDTH  operand to shared multiplier.
REQ-010 m_valid_out  output  1  operand valid to multiplier.
REQ-011 m_ready_in  input  1  multiplier accepts operand.
REQ-012 m_y  input  WIDTH  multiplier result.
REQ-013 m_valid_in  input  1  multiplier result valid.
REQ-014 m_ready_out  output  1  block accepts result.
REQ-015 o_y  output  WIDTH  routed result.
REQ-016 o_id  output  clog2(N)  requester index owning o_y.
REQ-017 o_valid_out  output  1  result valid.
REQ-018 o_ready_in  input  1  downstream accepts result.
REQ-019 o_err  output  1  sticky error: result arrived with no outstanding tag.

Function
REQ-020 Transfer on any channel occurs in a cycle where valid and ready are both high; valid, once raised, holds with stable data until the transfer.
REQ-021 Issue stage: m_x/m_valid_out registered; can_issue = (~m_valid_out | m_ready_in) & ~tag_full, tag_full from registered occupancy only.
REQ-022 Grant: combinational round-robin over i_valid_in, starting search at pointer rr; i_ready_out[g] = can_issue for the granted g, all other bits 0.
REQ-023 On acceptance from requester g: m_x <= i_x[g], m_valid_out <= 1, g pushed into tag FIFO, rr <= (g+1) mod N.
REQ-024 No acceptance: rr unchanged; m_valid_out cleared when m_ready_in high, else held with m_x unchanged.
REQ-025 Latency: request accepted in cycle t appears on m_x/m_valid_out in cycle t+1.
REQ-026 Results return in issue order; multiplier latency arbitrary, including back-to-back.
REQ-027 m_ready_out = ~o_valid_out | o_ready_in.
REQ-028 On result transfer with FIFO non-empty: o_y <= m_y, o_id <= FIFO head, o_valid_out <= 1, head popped.
REQ-029 On result transfer with FIFO empty: result dropped, o_err <= 1, o_valid_out unaffected by the drop.
REQ-030 o_valid_out cleared after downstream transfer unless a new result loads same cycle (full throughput, one result per cycle).
REQ-031 Simultaneous push and pop: occupancy unchanged; push still blocked if occupancy was DEPTH at cycle start.
REQ-032 FIFO pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-033 Requester deasserting valid before grant is legal; no state change.

Reset
REQ-034 rst low asynchronously forces: m_valid_out=0, m_x=0, o_valid_out=0, o_y=0, o_id=0, o_err=0, rr=0, FIFO empty.
REQ-035 Reset mid-operation discards all outstanding tags; results arriving after release with empty FIFO set o_err.
REQ-036 i_ready_out is 0 while rst low.

Verification
REQ-037 All 4 requesters valid continuously, m_ready_in=1, 1-cycle multiplier, o_ready_in=1 -> grants 0,1,2,3,0 in consecutive cycles; o_id sequence 0,1,2,3,0.
REQ-038 Only requester 2 valid, x=5, multiplier returns 505 -> o_y=505, o_id=2, one o_valid_out pulse; rr=3.
REQ-039 Multiplier stalls results (m_valid_in=0) after 4 issues -> fifth request not accepted, i_ready_out=0 until first result transfers.
REQ-040 o_ready_in=0 with result held -> m_ready_out=0, o_y/o_id stable; release -> next result on following cycle.
REQ-041 Result injected with no outstanding request -> o_err=1, stays 1 until rst; o_valid_out stays 0.
REQ-042 rst asserted with 3 tags outstanding and m_valid_out=1 -> all outputs at reset values immediately, before next clk edge.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin front end for a shared multiplier. N requesters compete for one
// operand port. The index of each issued operand is held in a tag FIFO, and
// each in-order result is returned together with the id of its requester.
module mult_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   i_x,
    input  logic [N-1:0]         i_valid_in,
    output logic [N-1:0]         i_ready_out,
    output logic [WIDTH-1:0]     m_x,
    output logic                 m_valid_out,
    input  logic                 m_ready_in,
    input  logic [WIDTH-1:0]     m_y,
    input  logic                 m_valid_in,
    output logic                 m_ready_out,
    output logic [WIDTH-1:0]     o_y,
    output logic [$clog2(N)-1:0] o_id,
    output logic                 o_valid_out,
    input  logic                 o_ready_in,
    output logic                 o_err
);

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  rr_next;
    logic             gnt_valid;
    logic [WIDTH-1:0] sel_x;
    logic             can_issue;
    logic             tag_full;
    logic             tag_empty;
    logic             accept;
    logic             res_xfer;
    logic             tag_pop;

    logic [ID_W-1:0]  tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;

    // Fullness and emptiness come only from the registered count, so a pop
    // in this cycle never frees a slot for a push in the same cycle.
    assign tag_full  = (tag_cnt == CNT_W'(DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign can_issue = (~m_valid_out | m_ready_in) & ~tag_full;
    assign accept    = rst & gnt_valid & can_issue;

    assign m_ready_out = ~o_valid_out | o_ready_in;
    assign res_xfer    = m_valid_in & m_ready_out;
    assign tag_pop     = res_xfer & ~tag_empty;

    // Round-robin search: the first valid requester at or after rr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int off = 0; off < int'(N); off++) begin
            cand = ID_W'((int'(rr) + off) % int'(N));
            if (!gnt_valid && i_valid_in[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Select the operand of the granted requester and drive its ready bit.
    always_comb begin
        sel_x       = '0;
        i_ready_out = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_x          = i_x[k*WIDTH +: WIDTH];
                i_ready_out[k] = rst & gnt_valid & can_issue;
            end
        end
    end

    assign rr_next = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Issue register toward the multiplier and the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_x         <= '0;
            m_valid_out <= 1'b0;
            rr          <= '0;
        end else if (accept) begin
            m_x         <= sel_x;
            m_valid_out <= 1'b1;
            rr          <= rr_next;
        end else if (m_ready_in) begin
            m_valid_out <= 1'b0;
        end
    end

    // Storage for the tags. It needs no reset because the pointers and the
    // count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end

    // Tag FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (tag_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (accept && !tag_pop) begin
                tag_cnt <= tag_cnt + CNT_W'(1);
            end else if (!accept && tag_pop) begin
                tag_cnt <= tag_cnt - CNT_W'(1);
            end
        end
    end

    // Result register. A result that arrives with no tag is dropped and
    // raises the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_y         <= '0;
            o_id        <= '0;
            o_valid_out <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (tag_pop) begin
                o_y         <= m_y;
                o_id        <= tag_mem[rd_ptr];
                o_valid_out <= 1'b1;
            end else if (o_ready_in) begin
                o_valid_out <= 1'b0;
            end
            if (res_xfer && tag_empty) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
